// File: rtl/div_iter.sv
// div_iter: multi-cycle radix-2 restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle with a zero result.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);
  typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH);

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [WIDTH-1:0]   r_rem, w_rem_next;
  logic [WIDTH-1:0]   r_quo, w_quo_next;
  logic [WIDTH-1:0]   r_dvs, w_dvs_next;
  logic               r_neg_q, w_neg_q_next;
  logic               r_neg_r, w_neg_r_next;
  logic [2*WIDTH-1:0] r_result, w_result_next;
  logic               r_ready, w_ready_next;

  logic [WIDTH-1:0]   w_abs1, w_abs2;
  logic [WIDTH:0]     w_rem_sh, w_trial;
  logic               w_start, w_done;

  assign w_start  = start_i && !annul_i;
  assign w_abs1   = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2   = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  // The shifted partial remainder can reach 2*|divisor|-1, hence one extra bit.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_dvs};
  assign w_done   = (r_cnt == LP_LAST);

  assign result_o = r_result;
  assign ready_o  = r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
`ifdef DIV_ZERO_FAST_EN
          w_state_next = (opdata2_i == '0) ? S_BY_ZERO : S_ON;
`else
          w_state_next = S_ON;
`endif
        end
      end
`ifdef DIV_ZERO_FAST_EN
      S_BY_ZERO: w_state_next = annul_i ? S_IDLE : S_END;
`endif
      S_ON: begin
        if (annul_i)     w_state_next = S_IDLE;
        else if (w_done) w_state_next = S_END;
      end
      S_END: begin
        if (annul_i || !start_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next    = r_cnt;
    w_rem_next    = r_rem;
    w_quo_next    = r_quo;
    w_dvs_next    = r_dvs;
    w_neg_q_next  = r_neg_q;
    w_neg_r_next  = r_neg_r;
    w_result_next = r_result;
    w_ready_next  = r_ready;
    case (r_state)
      S_IDLE: begin
        w_result_next = '0;
        w_ready_next  = 1'b0;
        if (w_start) begin
          w_cnt_next   = '0;
          w_rem_next   = '0;
          w_quo_next   = w_abs1;
          w_dvs_next   = w_abs2;
          w_neg_q_next = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          w_neg_r_next = signed_div_i && opdata1_i[WIDTH-1];
        end
      end
`ifdef DIV_ZERO_FAST_EN
      S_BY_ZERO: begin
        w_result_next = '0;
        w_ready_next  = !annul_i;
      end
`endif
      S_ON: begin
        if (annul_i) begin
          w_result_next = '0;
          w_ready_next  = 1'b0;
        end else if (!w_done) begin
          w_cnt_next = r_cnt + 1'b1;
          if (!w_trial[WIDTH]) begin
            w_rem_next = w_trial[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            w_rem_next = w_rem_sh[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
          end
        end else begin
          w_result_next = {(r_neg_r ? -r_rem : r_rem), (r_neg_q ? -r_quo : r_quo)};
          w_ready_next  = 1'b1;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          w_result_next = '0;
          w_ready_next  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_rem    <= w_rem_next;
      r_quo    <= w_quo_next;
      r_dvs    <= w_dvs_next;
      r_neg_q  <= w_neg_q_next;
      r_neg_r  <= w_neg_r_next;
      r_result <= w_result_next;
      r_ready  <= w_ready_next;
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter (WIDTH=32 and WIDTH=8 instances).
// Stimulus pushes expected {result, latency}; monitors pop on each rising ready_o.
module tb_div_iter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sgn, start, annul;
  logic [31:0] a, b;
  logic [63:0] res;
  logic        rdy;
  logic        sgn8, start8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        rdy8;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          e0;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t cur32, cur8;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  logic prev_rdy = 1'b0;
  logic prev_rdy8 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  div_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .start_i(start), .annul_i(annul), .result_o(res), .ready_o(rdy)
  );

  div_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul), .result_o(res8), .ready_o(rdy8)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin : mon32
    exp_t e;
    if (rdy && !prev_rdy) begin
      if (q32.size() == 0) check("unexpected_ready", 64'(rdy), 64'd0);
      else begin
        e = q32.pop_front();
        check("result", res, e.res);
        check("latency", 64'(edge_cnt - e.e0), 64'(e.lat));
        cur32 <= e;
      end
    end else if (rdy) check("hold", res, cur32.res);
    else if (prev_rdy) check("drop_result", res, 64'd0);
    prev_rdy <= rdy;
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rdy8 && !prev_rdy8) begin
      if (q8.size() == 0) check("unexpected_ready8", 64'(rdy8), 64'd0);
      else begin
        e = q8.pop_front();
        check("result8", 64'(res8), e.res);
        check("latency8", 64'(edge_cnt - e.e0), 64'(e.lat));
        cur8 <= e;
      end
    end else if (rdy8) check("hold8", 64'(res8), cur8.res);
    else if (prev_rdy8) check("drop_result8", 64'(res8), 64'd0);
    prev_rdy8 <= rdy8;
  end

  task automatic start_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] e, input int lat);
    @(negedge clk);
    sgn = s; a = x; b = y; start = 1'b1;
    q32.push_back('{e, lat, edge_cnt + 1});
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h00001234; sgn = ~sgn;
    while (!rdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) check("timeout", 64'(rdy), 64'd1);
  endtask

  task automatic drop_op();
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(rdy), 64'd0);
  endtask

  task automatic div32(input logic s, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] e, input int lat);
    start_op(s, x, y, e, lat);
    wait_ready();
    drop_op();
  endtask

  task automatic div8(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
    int n = 0;
    @(negedge clk);
    sgn8 = 1'b1; a8 = x; b8 = y; start8 = 1'b1;
    q8.push_back('{64'(e), 9, edge_cnt + 1});
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h00;
    while (!rdy8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!rdy8) check("timeout8", 64'(rdy8), 64'd1);
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    check("drop_ready8", 64'(rdy8), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sgn = 1'b0; start = 1'b0; annul = 1'b0; a = '0; b = '0;
    sgn8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    check("reset_ready", 64'(rdy), 64'd0);
    check("reset_result", res, 64'd0);
    check("reset_ready8", 64'(rdy8), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    div32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    div32(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33);
    div32(1'b1, 32'd100, 32'hFFFFFFF9, {32'd2, 32'hFFFFFFF2}, 33);
    div32(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14}, 33);
    div32(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 33);
    div32(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 33);
    div32(1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);
    div32(1'b0, 32'hFFFFFFFF, 32'h80000001, {32'h7FFFFFFE, 32'd1}, 33);
    div32(1'b0, 32'hFFFFFFFF, 32'h00000010, {32'h0000000F, 32'h0FFFFFFF}, 33);
`ifdef DIV_ZERO_FAST_EN
    div32(1'b0, 32'd123, 32'd0, 64'd0, 1);
    div32(1'b1, 32'hFFFFFFFB, 32'd0, 64'd0, 1);
`else
    div32(1'b0, 32'd123, 32'd0, {32'd123, 32'hFFFFFFFF}, 33);
    div32(1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'd1}, 33);
    div32(1'b1, 32'd123, 32'd0, {32'd123, 32'hFFFFFFFF}, 33);
`endif

    // Annul at iteration 10: ready must never rise.
    @(negedge clk);
    sgn = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    check("annul_ready", 64'(rdy), 64'd0);
    check("annul_result", res, 64'd0);
    annul = 1'b0; start = 1'b0;
    repeat (40) @(negedge clk);
    check("annul_no_ready", 64'(rdy), 64'd0);

    // Reset at iteration 20.
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (21) @(negedge clk);
    #1 rst = 1'b0; start = 1'b0;
    #1 check("rst_mid_ready", 64'(rdy), 64'd0);
    check("rst_mid_result", res, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    div32(1'b0, 32'd9, 32'd2, {32'd1, 32'd4}, 33);

    // Reset while holding a result: outputs clear before the next clock edge.
    start_op(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);
    wait_ready();
    #2 rst = 1'b0;
    #1 check("rst_end_ready", 64'(rdy), 64'd0);
    check("rst_end_result", res, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    div8(8'h80, 8'd3, {8'hFE, 8'hD6});
    div8(8'hF9, 8'd2, {8'hFF, 8'hFD});

    repeat (3) @(negedge clk);
    check("queue32_empty", 64'(q32.size()), 64'd0);
    check("queue8_empty", 64'(q8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the OpenMIPS EX stage, backing the DIV/DIVU instructions.
- Generalises the single-cycle pipeline datapath in two ways: configurable WIDTH, and a signed/unsigned mode.
- EX issues start_i and waits on ready_o while the pipeline stalls. The result is written to HI/LO.

Parameters:
- WIDTH, 32: operand width in bits; must be ≥ 4.
- CNT_W, 6: iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  in  WIDTH  dividend; sampled with start_i.
- opdata2_i  in  WIDTH  divisor; sampled with start_i.
- start_i  in  1  request; held high by EX until ready_o is seen.
- annul_i  in  1  abort (pipeline flush/exception).
- result_o  out  2*WIDTH  {remainder, quotient}, registered.
- ready_o  out  1  result valid, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, all datapath registers cleared.
  - result_o=0, ready_o=0.
  - Reset mid-division discards the operation immediately.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - If start_i=1 and annul_i=0: latch operands and mode.
  - In signed mode, take magnitudes of negative operands (two's complement).
  - Go to ON with counter=0, partial remainder=0, shift register=|dividend|.
  - Otherwise stay in IDLE with ready_o=0, result_o=0.
- ON, one quotient bit per clock, MSB first:
  - Shift {partial remainder, shift reg} left by 1.
  - Trial-subtract |divisor| from the partial remainder, computed WIDTH+1 bits wide.
  - If non-negative: keep the difference and shift in quotient bit 1; else shift in 0.
  - Counter increments each cycle; after WIDTH iterations go to END.
- Sign fix on ON→END:
  - Quotient is negated when signed mode and sign(dividend) ≠ sign(divisor).
  - Remainder is negated when signed mode and dividend negative.
- END:
  - ready_o=1; result_o holds the final value, stable every cycle.
  - When start_i=0: go to IDLE; ready_o=0 and result_o=0 on that edge.
- Latency: start_i sampled at edge E0 → ready_o=1 after edge E0+WIDTH+1 (33 edges for WIDTH=32).
- annul_i:
  - annul_i=1 in ON or END → IDLE at the next edge, ready_o=0, result_o=0.
  - annul_i overrides start_i in every state.
- Signed overflow: MIN/−1 gives quotient=MIN bit pattern, remainder=0; no flag.
- Divide by zero without the optional feature: normal iteration.
  - Unsigned: quotient=all ones, remainder=dividend.
  - Signed: quotient=−1 if dividend≥0 else +1; remainder=dividend.
- start_i arriving in ON is ignored; the operands are not re-latched.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - IDLE with start_i and divisor=0 → BY_ZERO.
  - BY_ZERO → END on the next edge with result_o=0, ready_o=1 after edge E0+1.
  - BY_ZERO honours annul_i.
- Undefined: BY_ZERO is not implemented; divide-by-zero follows the normal WIDTH-iteration path and results above.

Test Plan:
- WIDTH=32, unsigned 100/7, start_i held → ready_o=1 after edge E0+33; result_o={32'd2, 32'd14}; drop start_i → next edge ready_o=0, result_o=0.
- Signed −100/7 → quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2); signed 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Unsigned 0xFFFFFFFF/0x00000001 → quotient 0xFFFFFFFF, remainder 0; unsigned 5/9 → quotient 0, remainder 5.
- Start 100/7, assert annul_i at iteration 10 → IDLE next edge, ready_o never rises. Repeat, pulling rst low at iteration 20 → outputs 0 immediately. A new 9/2 then yields {1, 4}.
- Divisor 0, dividend 123, unsigned:
  - Macro undefined → ready after 33 edges, {32'd123, 0xFFFFFFFF}.
  - Macro defined → ready after edge E0+1, result_o=0.
- WIDTH=8, CNT_W=4, signed −128/3 → ready after 9 edges, quotient 0xD6 (−42), remainder 0xFE (−2).
